// File: rtl/mc_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB controller for the MIPS-subset CPU.
// Ports: clk, reset (async, active-low), opcode/funct/zero/mem_ready in;
// state, write strobes, datapath selects, retired count, sticky errors out.
module mc_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  state,
  output logic        PCWr,
  output logic        IRWr,
  output logic        RFWr,
  output logic        DMWr,
  output logic        mem_req,
  output logic [1:0]  NPCOp,
  output logic [1:0]  RegDst,
  output logic        ALUSrc,
  output logic [3:0]  ALUOp,
  output logic [2:0]  DMOp,
  output logic [1:0]  MemtoReg,
  output logic        EXTOp,
  output logic [31:0] retired,
  output logic        illegal,
  output logic        mem_err
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    C_RTYPE, C_IMM, C_LOAD, C_STORE,
    C_BEQ, C_J, C_JAL, C_JR
  } cls_t;

  state_t      r_state;
  cls_t        r_cls;
  logic [1:0]  r_npc;
  logic [1:0]  r_regdst;
  logic        r_alusrc;
  logic [3:0]  r_aluop;
  logic [2:0]  r_dmop;
  logic [1:0]  r_m2r;
  logic        r_ext;
  logic [7:0]  r_wait;
  logic [31:0] r_retired;
  logic        r_illegal;
  logic        r_mem_err;

  cls_t        w_cls;
  logic        w_legal;
  logic [1:0]  w_npc;
  logic [1:0]  w_regdst;
  logic        w_alusrc;
  logic [3:0]  w_aluop;
  logic [2:0]  w_dmop;
  logic [1:0]  w_m2r;
  logic        w_ext;
  logic        w_rtype;
  logic        w_wait_last;

  assign w_rtype     = (opcode == 6'b000000);
  assign w_wait_last = (r_wait == 8'(TIMEOUT - 1));

  // Unrecognized encodings leave every select at 0 and clear w_legal.
  always_comb begin
    w_cls    = C_RTYPE;
    w_legal  = 1'b1;
    w_npc    = 2'd0;
    w_regdst = 2'd0;
    w_alusrc = 1'b0;
    w_aluop  = 4'd0;
    w_dmop   = 3'd0;
    w_m2r    = 2'd0;
    w_ext    = 1'b0;
    unique case (1'b1)
      (w_rtype && funct == 6'b100001): begin
        w_regdst = 2'd1;
      end
      (w_rtype && funct == 6'b100011): begin
        w_regdst = 2'd1;
        w_aluop  = 4'd1;
      end
      (w_rtype && funct == 6'b000000): begin
        w_regdst = 2'd1;
        w_aluop  = 4'd3;
      end
      (w_rtype && funct == 6'b001000): begin
        w_cls = C_JR;
        w_npc = 2'd3;
      end
      (opcode == 6'b001101): begin
        w_cls    = C_IMM;
        w_alusrc = 1'b1;
        w_aluop  = 4'd2;
      end
      (opcode == 6'b001111): begin
        w_cls    = C_IMM;
        w_alusrc = 1'b1;
        w_aluop  = 4'd4;
      end
      (opcode == 6'b000100): begin
        w_cls   = C_BEQ;
        w_npc   = 2'd1;
        w_aluop = 4'd1;
        w_ext   = 1'b1;
      end
      (opcode == 6'b000010): begin
        w_cls = C_J;
        w_npc = 2'd2;
      end
      (opcode == 6'b000011): begin
        w_cls    = C_JAL;
        w_npc    = 2'd2;
        w_regdst = 2'd2;
        w_m2r    = 2'd2;
      end
      (opcode == 6'b100011 || opcode == 6'b100001 ||
       opcode == 6'b100101 || opcode == 6'b100000 ||
       opcode == 6'b100100): begin
        w_cls    = C_LOAD;
        w_alusrc = 1'b1;
        w_m2r    = 2'd1;
        w_ext    = 1'b1;
        unique case (opcode)
          6'b100001: w_dmop = 3'd1;
          6'b100101: w_dmop = 3'd2;
          6'b100000: w_dmop = 3'd3;
          6'b100100: w_dmop = 3'd4;
          default:   w_dmop = 3'd0;
        endcase
      end
      (opcode == 6'b101011 || opcode == 6'b101001 ||
       opcode == 6'b101000): begin
        w_cls    = C_STORE;
        w_alusrc = 1'b1;
        w_ext    = 1'b1;
        unique case (opcode)
          6'b101001: w_dmop = 3'd1;
          6'b101000: w_dmop = 3'd3;
          default:   w_dmop = 3'd0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_FETCH;
      r_cls     <= C_RTYPE;
      r_npc     <= 2'd0;
      r_regdst  <= 2'd0;
      r_alusrc  <= 1'b0;
      r_aluop   <= 4'd0;
      r_dmop    <= 3'd0;
      r_m2r     <= 2'd0;
      r_ext     <= 1'b0;
      r_wait    <= 8'd0;
      r_retired <= 32'd0;
      r_illegal <= 1'b0;
      r_mem_err <= 1'b0;
    end else begin
      unique case (r_state)
        S_FETCH: r_state <= S_DECODE;
        S_DECODE: begin
          r_cls    <= w_cls;
          r_npc    <= w_npc;
          r_regdst <= w_regdst;
          r_alusrc <= w_alusrc;
          r_aluop  <= w_aluop;
          r_dmop   <= w_dmop;
          r_m2r    <= w_m2r;
          r_ext    <= w_ext;
          if (w_legal) begin
            r_state <= S_EXEC;
          end else begin
            r_illegal <= 1'b1;
            r_state   <= S_FETCH;
          end
        end
        S_EXEC: begin
          unique case (r_cls)
            C_RTYPE, C_IMM: r_state <= S_WB;
            C_LOAD, C_STORE: begin
              r_wait  <= 8'd0;
              r_state <= S_MEM;
            end
            default: begin
              r_retired <= r_retired + 32'd1;
              r_state   <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (r_cls == C_STORE) begin
              r_retired <= r_retired + 32'd1;
              r_state   <= S_FETCH;
            end else begin
              r_state <= S_WB;
            end
          end else if (w_wait_last) begin
            r_mem_err <= 1'b1;
            r_state   <= S_FETCH;
          end else begin
            r_wait <= r_wait + 8'd1;
          end
        end
        S_WB: begin
          r_retired <= r_retired + 32'd1;
          r_state   <= S_FETCH;
        end
        default: r_state <= S_FETCH;
      endcase
    end
  end

  assign state    = r_state;
  assign IRWr     = (r_state == S_FETCH);
  assign mem_req  = (r_state == S_MEM);
  assign DMWr     = (r_state == S_MEM) && (r_cls == C_STORE);
  assign RFWr     = (r_state == S_WB) ||
                    ((r_state == S_EXEC) && (r_cls == C_JAL));
  assign PCWr     = (r_state == S_FETCH) ||
                    ((r_state == S_EXEC) &&
                     ((r_cls == C_BEQ && zero) ||
                      r_cls == C_J || r_cls == C_JAL ||
                      r_cls == C_JR));
  // FETCH always loads PC+4 regardless of the latched branch kind.
  assign NPCOp    = (r_state == S_FETCH) ? 2'd0 : r_npc;
  assign RegDst   = r_regdst;
  assign ALUSrc   = r_alusrc;
  assign ALUOp    = r_aluop;
  assign DMOp     = r_dmop;
  assign MemtoReg = r_m2r;
  assign EXTOp    = r_ext;
  assign retired  = r_retired;
  assign illegal  = r_illegal;
  assign mem_err  = r_mem_err;

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed self-checking bench for mc_ctrl.
// Inputs change and outputs are sampled on the falling edge.
module tb_mc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  state;
  logic        PCWr, IRWr, RFWr, DMWr, mem_req;
  logic [1:0]  NPCOp, RegDst, MemtoReg;
  logic        ALUSrc, EXTOp;
  logic [3:0]  ALUOp;
  logic [2:0]  DMOp;
  logic [31:0] retired;
  logic        illegal, mem_err;

  int n_assert = 0;
  int n_fail   = 0;

  mc_ctrl #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset),
    .opcode(opcode), .funct(funct),
    .zero(zero), .mem_ready(mem_ready),
    .state(state),
    .PCWr(PCWr), .IRWr(IRWr), .RFWr(RFWr),
    .DMWr(DMWr), .mem_req(mem_req),
    .NPCOp(NPCOp), .RegDst(RegDst),
    .ALUSrc(ALUSrc), .ALUOp(ALUOp),
    .DMOp(DMOp), .MemtoReg(MemtoReg),
    .EXTOp(EXTOp), .retired(retired),
    .illegal(illegal), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(negedge clk);
  endtask

  // FETCH -> DECODE -> EXEC -> WB -> FETCH
  task automatic run_alu(input string tag,
                         input logic [5:0] op,
                         input logic [5:0] fn,
                         input int aluop, input int alusrc,
                         input int regdst, input int ret);
    opcode = op; funct = fn;
    chk({tag, " F"}, 32'(state), 0);
    nxt; nxt;
    chk({tag, " E"}, 32'(state), 2);
    chk({tag, " aluop"}, 32'(ALUOp), aluop);
    chk({tag, " alusrc"}, 32'(ALUSrc), alusrc);
    chk({tag, " regdst"}, 32'(RegDst), regdst);
    nxt;
    chk({tag, " WB"}, 32'(state), 4);
    chk({tag, " rfwr"}, 32'(RFWr), 1);
    nxt;
    chk({tag, " ret"}, retired, ret);
  endtask

  // FETCH -> DECODE -> EXEC -> FETCH
  task automatic run_jmp(input string tag,
                         input logic [5:0] op,
                         input logic [5:0] fn,
                         input int npc, input int ret);
    opcode = op; funct = fn;
    nxt; nxt;
    chk({tag, " E"}, 32'(state), 2);
    chk({tag, " pcwr"}, 32'(PCWr), 1);
    chk({tag, " npc"}, 32'(NPCOp), npc);
    nxt;
    chk({tag, " F"}, 32'(state), 0);
    chk({tag, " ret"}, retired, ret);
  endtask

  initial begin
    reset = 1'b0; opcode = '0; funct = '0;
    zero = 1'b0; mem_ready = 1'b0;
    nxt; nxt;
    chk("rst state", 32'(state), 0);
    chk("rst irwr", 32'(IRWr), 1);
    chk("rst pcwr", 32'(PCWr), 1);
    chk("rst retired", retired, 0);
    chk("rst illegal", 32'(illegal), 0);
    chk("rst memerr", 32'(mem_err), 0);
    reset = 1'b1;

    // addu, mem_ready low throughout
    opcode = 6'b000000; funct = 6'b100001;
    chk("addu F", 32'(state), 0);
    nxt;
    chk("addu D", 32'(state), 1);
    chk("addu D rfwr", 32'(RFWr), 0);
    chk("addu D pcwr", 32'(PCWr), 0);
    nxt;
    chk("addu E", 32'(state), 2);
    chk("addu E rfwr", 32'(RFWr), 0);
    chk("addu regdst", 32'(RegDst), 1);
    nxt;
    chk("addu WB", 32'(state), 4);
    chk("addu WB rfwr", 32'(RFWr), 1);
    nxt;
    chk("addu F2", 32'(state), 0);
    chk("addu ret", retired, 1);

    // lw with two wait cycles
    opcode = 6'b100011; funct = '0;
    nxt; nxt;
    chk("lw E ext", 32'(EXTOp), 1);
    chk("lw E alusrc", 32'(ALUSrc), 1);
    for (int i = 0; i < 3; i++) begin
      nxt;
      mem_ready = (i == 2);
      chk("lw MEM", 32'(state), 3);
      chk("lw req", 32'(mem_req), 1);
      chk("lw dmwr", 32'(DMWr), 0);
    end
    nxt;
    mem_ready = 1'b0;
    chk("lw WB", 32'(state), 4);
    chk("lw m2r", 32'(MemtoReg), 1);
    chk("lw dmop", 32'(DMOp), 0);
    chk("lw rfwr", 32'(RFWr), 1);
    nxt;
    chk("lw F", 32'(state), 0);
    chk("lw ret", retired, 2);

    // beq taken, then not taken
    zero = 1'b1;
    run_jmp("beq1", 6'b000100, 6'b0, 1, 3);
    zero = 1'b0;
    opcode = 6'b000100;
    nxt; nxt;
    chk("beq0 E", 32'(state), 2);
    chk("beq0 pcwr", 32'(PCWr), 0);
    nxt;
    chk("beq0 F", 32'(state), 0);
    chk("beq0 ret", retired, 4);

    // jal
    opcode = 6'b000011;
    nxt; nxt;
    chk("jal pcwr", 32'(PCWr), 1);
    chk("jal rfwr", 32'(RFWr), 1);
    chk("jal regdst", 32'(RegDst), 2);
    chk("jal m2r", 32'(MemtoReg), 2);
    chk("jal npc", 32'(NPCOp), 2);
    nxt;
    chk("jal F", 32'(state), 0);
    chk("jal F npc", 32'(NPCOp), 0);
    chk("jal ret", retired, 5);

    // sb timeout
    opcode = 6'b101000; mem_ready = 1'b0;
    nxt; nxt;
    for (int i = 0; i < 15; i++) begin
      nxt;
      chk("sb MEM", 32'(state), 3);
      chk("sb dmwr", 32'(DMWr), 1);
      chk("sb memerr", 32'(mem_err), 0);
    end
    chk("sb dmop", 32'(DMOp), 3);
    nxt;
    chk("sb F", 32'(state), 0);
    chk("sb memerr set", 32'(mem_err), 1);
    chk("sb ret", retired, 5);

    // sw completes immediately
    opcode = 6'b101011; mem_ready = 1'b1;
    nxt; nxt; nxt;
    chk("sw MEM", 32'(state), 3);
    chk("sw dmwr", 32'(DMWr), 1);
    nxt;
    chk("sw F", 32'(state), 0);
    chk("sw ret", retired, 6);
    chk("sw memerr", 32'(mem_err), 1);

    // illegal opcode
    opcode = 6'b111111; mem_ready = 1'b0;
    nxt;
    chk("ill D", 32'(state), 1);
    nxt;
    chk("ill F", 32'(state), 0);
    chk("ill flag", 32'(illegal), 1);
    chk("ill ret", retired, 6);

    // async reset mid lw MEM wait
    opcode = 6'b100011;
    nxt; nxt; nxt; nxt;
    chk("rlw MEM", 32'(state), 3);
    reset = 1'b0;
    #1;
    chk("arst state", 32'(state), 0);
    chk("arst retired", retired, 0);
    chk("arst illegal", 32'(illegal), 0);
    chk("arst memerr", 32'(mem_err), 0);
    chk("arst m2r", 32'(MemtoReg), 0);
    chk("arst irwr", 32'(IRWr), 1);
    nxt;
    reset = 1'b1;

    // sh: ready only in the 15th MEM cycle
    opcode = 6'b101001;
    nxt; nxt;
    for (int i = 0; i < 15; i++) begin
      nxt;
      mem_ready = (i == 14);
      chk("sh MEM", 32'(state), 3);
    end
    chk("sh dmop", 32'(DMOp), 1);
    nxt;
    mem_ready = 1'b0;
    chk("sh F", 32'(state), 0);
    chk("sh memerr", 32'(mem_err), 0);
    chk("sh ret", retired, 1);

    run_alu("lui", 6'b001111, 6'b0, 4, 1, 0, 2);
    run_alu("subu", 6'b000000, 6'b100011, 1, 0, 1, 3);
    run_alu("sll", 6'b000000, 6'b000000, 3, 0, 1, 4);
    run_alu("ori", 6'b001101, 6'b0, 2, 1, 0, 5);
    run_jmp("jr", 6'b000000, 6'b001000, 3, 6);
    run_jmp("j", 6'b000010, 6'b0, 2, 7);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
